uart_ctrl: RTL and testbench

Controller for the UART peripheral of the pipelined MIPS CPU.
- Generates the 16x-oversample baud clock (BRclk) that feeds the receiver and transmitter.
- Captures completed receive bytes into a small RX FIFO.
- Sequences the transmitter through a one-byte holding register and launch/busy handshake.
- Exposes data/status/control registers to the CPU memory-mapped bus, with an optional interrupt.

---
 rtl/uart_ctrl_if.sv | 13 +
 rtl/uart_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_if.sv
// CPU-side memory-mapped bus for the UART controller window.
// The CPU (or bench) uses the master modport and the controller uses the slave modport.
interface uart_ctrl_if;
  logic        sel;
  logic        rd;
  logic        wr;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, rd, wr, addr, wdata, input rdata);
  modport slave  (input sel, rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_ctrl.sv
// UART controller: baud clock generator, RX byte FIFO, TX holding register/launch FSM, CPU registers.
// Optional interrupt output is enabled by defining UART_IRQ_EN.
module uart_ctrl #(
  parameter int CLK_HZ   = 100000000,
  parameter int BAUD     = 9600,
  parameter int RX_DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  uart_ctrl_if.slave  bus,
  output logic        BRclk,
  input  logic        rx_status,
  input  logic [7:0]  rx_data,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_status,
  output logic        irq
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * 32);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW      = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic          br_q, br_d;
  logic          rx_status_q, rx_status_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    rx_mem_q [RX_DEPTH];
  state_t        state_q;
  logic          tx_en_q;
  logic [7:0]    tx_data_q;
  logic [1:0]    irq_en;
  logic [31:0]   rdata_c;

  logic rd_acc, wr_acc, con_rd, con_wr, wr_txd;
  logic rx_avail, fifo_full, push, pop, push_ok, new_ovr, hold_take;
  logic unused_wdata;

  // A simultaneous rd+wr is treated purely as a write.
  assign rd_acc = bus.sel & bus.rd & ~bus.wr;
  assign wr_acc = bus.sel & bus.wr;
  assign con_rd = rd_acc & (bus.addr == 4'h8);
  assign con_wr = wr_acc & (bus.addr == 4'h8);
  assign wr_txd = wr_acc & (bus.addr == 4'h0);
  assign unused_wdata = ^bus.wdata[31:8];

  assign rx_avail  = (count_q != '0);
  assign fifo_full = (count_q == FULL_CNT);
  assign push      = rx_status & ~rx_status_q;
  assign pop       = rd_acc & (bus.addr == 4'h4) & rx_avail;
  assign push_ok   = push & (~fifo_full | pop);
  assign new_ovr   = push & fifo_full & ~pop;
  assign hold_take = (state_q == S_IDLE) & hold_full_q;

  always_comb begin
    baud_cnt_d  = baud_cnt_q + 1'b1;
    br_d        = br_q;
    if (baud_cnt_q == DIV_LAST) begin
      baud_cnt_d = '0;
      br_d       = ~br_q;
    end
    rx_status_d = rx_status;
    wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    // A new overrun in the same cycle as a CON read must survive the clear.
    overrun_d = overrun_q;
    if (con_rd)  overrun_d = 1'b0;
    if (new_ovr) overrun_d = 1'b1;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (hold_take) hold_full_d = 1'b0;
    if (wr_txd && (!hold_full_q || hold_take)) begin
      hold_d      = bus.wdata[7:0];
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      baud_cnt_q  <= '0;
      br_q        <= 1'b0;
      rx_status_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      baud_cnt_q  <= baud_cnt_d;
      br_q        <= br_d;
      rx_status_q <= rx_status_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge sysclk) begin
    if (push_ok) rx_mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_en_q <= 1'b0;
      case (state_q)
        S_IDLE: if (hold_full_q) begin
          tx_data_q <= hold_q;
          tx_en_q   <= 1'b1;
          state_q   <= S_LAUNCH;
        end
        S_LAUNCH:    state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (tx_status)  state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (!tx_status) state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

`ifdef UART_IRQ_EN
  logic [1:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  always_comb begin
    irq_en_d = con_wr ? bus.wdata[1:0] : irq_en_q;
    irq_d    = (irq_en_q[0] & rx_avail) |
               (irq_en_q[1] & ~hold_full_q & (state_q == S_IDLE));
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 2'b00;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rdata_c = '0;
    case (bus.addr)
      4'h0: rdata_c[7:0] = tx_data_q;
      4'h4: if (rx_avail) rdata_c[7:0] = rx_mem_q[rd_ptr_q];
      4'h8: rdata_c[5:0] = {hold_full_q, overrun_q, (state_q != S_IDLE), rx_avail, irq_en};
      default: rdata_c = '0;
    endcase
  end

  assign bus.rdata = rdata_c;
  assign BRclk     = br_q;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl; define UART_IRQ_EN to also exercise the interrupt.
module tb_uart_ctrl;
  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       BRclk, tx_en, irq;
  logic       rx_status, tx_status;
  logic [7:0] rx_data, tx_data;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 sysclk = ~sysclk;

  uart_ctrl_if bus ();

  uart_ctrl #(.CLK_HZ(100000000), .BAUD(9600), .RX_DEPTH(4)) dut (
    .sysclk(sysclk), .reset(reset), .bus(bus), .BRclk(BRclk),
    .rx_status(rx_status), .rx_data(rx_data), .tx_en(tx_en),
    .tx_data(tx_data), .tx_status(tx_status), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("vec %0d %s obs=0x%0h exp=0x%0h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.wdata = d;
    tick();
    bus.sel = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
    #1;
    d = bus.rdata;
    tick();
    bus.sel = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b; rx_status = 1'b1;
    tick(); tick();
    rx_status = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  exp_q [4];
    int          n;
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    bus.sel = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 4'h0; bus.wdata = '0;
    rx_status = 1'b0; rx_data = '0; tx_status = 1'b0;

    reset = 1'b1;
    repeat (3) tick();
    check("rst_brclk", BRclk, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_irq", irq, 0);
    peek(4'h8, d); check("rst_con", d, 0);
    peek(4'h4, d); check("rst_rxd_empty", d, 0);
    reset = 1'b0;

    n = 0; while (BRclk !== 1'b1 && n < 2000) begin tick(); n++; end
    check("br_first_rise", n, 325);
    n = 0; while (BRclk !== 1'b0 && n < 2000) begin tick(); n++; end
    check("br_high_half", n, 325);
    n = 0; while (BRclk !== 1'b1 && n < 2000) begin tick(); n++; end
    check("br_low_half", n, 325);

    rx_data = 8'h5A; rx_status = 1'b1;
    repeat (20) tick();
    rx_status = 1'b0; tick();
    cpu_read(4'h8, d); check("rx1_con_avail", d, 32'h04);
    cpu_read(4'h4, d); check("rx1_rxd", d, 32'h5A);
    cpu_read(4'h8, d); check("rx1_con_empty", d, 32'h00);

    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    cpu_read(4'h8, d); check("ovr_con", d, 32'h14);
    for (int i = 1; i <= 4; i++) begin
      cpu_read(4'h4, d); check("ovr_rxd", d, 32'(i));
    end
    cpu_read(4'h8, d); check("ovr_con_cleared", d, 32'h00);
    cpu_read(4'h4, d); check("rxd_empty_read", d, 32'h00);

    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    rx_data = 8'h55; rx_status = 1'b1;
    cpu_read(4'h4, d); check("full_pushpop_rxd", d, 32'h11);
    rx_status = 1'b0; tick();
    cpu_read(4'h8, d); check("full_pushpop_con", d, 32'h04);
    for (int i = 0; i < 4; i++) begin
      cpu_read(4'h4, d); check("full_pushpop_order", d, {24'h0, exp_q[i]});
    end

    cpu_write(4'h8, 32'hFFFF_FFFF);
    cpu_read(4'h8, d);
`ifdef UART_IRQ_EN
    check("con_wr_en", d, 32'h03);
`else
    check("con_wr_en", d, 32'h00);
`endif
    cpu_write(4'h8, 32'h0);
    cpu_write(4'h4, 32'hFF);
    cpu_read(4'h8, d); check("rxd_write_noop", d, 32'h00);

    cpu_write(4'h0, 32'h41);
    check("tx1_no_pulse_yet", tx_en, 0);
    peek(4'h8, d); check("tx1_con_hold", d, 32'h20);
    cpu_write(4'h0, 32'h42);
    check("tx1_pulse", tx_en, 1);
    check("tx1_data", tx_data, 8'h41);
    peek(4'h8, d); check("tx1_con_busy_hold", d, 32'h28);
    cpu_write(4'h0, 32'h43);
    check("tx1_pulse_one_cycle", tx_en, 0);
    tx_status = 1'b1;
    n = 0; repeat (100) begin tick(); if (tx_en) n++; end
    check("tx_busy_no_pulse", n, 0);
    tx_status = 1'b0;
    n = 0; while (!tx_en && n < 10) begin tick(); n++; end
    check("tx2_latency", n, 2);
    check("tx2_data", tx_data, 8'h42);
    tx_status = 1'b1; repeat (5) tick();
    tx_status = 1'b0;
    n = 0; repeat (20) begin tick(); if (tx_en) n++; end
    check("tx3_dropped", n, 0);
    cpu_read(4'h0, d); check("txd_read", d, 32'h42);
    cpu_read(4'h8, d); check("tx_con_idle", d, 32'h00);

    cpu_write(4'h0, 32'h61);
    n = 0; while (!tx_en && n < 10) begin tick(); n++; end
    check("rst_tx_launch", tx_en, 1);
    tx_status = 1'b1; tick(); tick();
    cpu_write(4'h0, 32'h62);
    peek(4'h8, d); check("rst_pre_con", d, 32'h28);
    reset = 1'b1;
    #1;
    check("midrst_tx_en", tx_en, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_brclk", BRclk, 0);
    check("midrst_irq", irq, 0);
    peek(4'h8, d); check("midrst_con", d, 32'h00);
    tick();
    reset = 1'b0; tx_status = 1'b0;
    n = 0; repeat (20) begin tick(); if (tx_en) n++; end
    check("postrst_no_launch", n, 0);
    check("postrst_tx_data", tx_data, 0);

    cpu_write(4'h8, 32'h1);
    push_byte(8'h33);
`ifdef UART_IRQ_EN
    check("irq_set", irq, 1);
    cpu_read(4'h4, d); check("irq_rxd", d, 32'h33);
    tick();
    check("irq_clear", irq, 0);
`else
    check("irq_tied_low", irq, 0);
    cpu_read(4'h4, d); check("irq_rxd", d, 32'h33);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
